rtc_bcd_core: RTL and testbench

Parametrised BCD timekeeping core for the VGA clock display. It generates the HH:MM:SS digits, a colour-offset counter, a one-second strobe and an alarm strobe. Time is set through a byte-wide register bus driven by the SPI command processor, and adjustment pulses come from the button pulse generators. The core sits between those blocks and the digit/font rendering path. It adds exact-period prescaling, legal-only digit values, a 12/24 h mode, run/stop control, an alarm and register readback.

---
 rtl/rtc_bcd_core.sv | 228 ++++++++++++++++++++++
 tb/tb_rtc_bcd_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bcd_core.sv
// BCD real-time clock core: exact-period prescaler, 24 h internal time with 12/24 h display,
// alarm and a byte-wide register bus with registered readback.
module rtc_bcd_core #(
    parameter int unsigned CLK_HZ       = 31500000,
    parameter int unsigned HOUR_MODE_24 = 1,
    parameter int unsigned COLOR_W      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               adj_sec,
    input  logic               adj_min,
    input  logic               adj_hrs,
    input  logic               wr_en,
    input  logic [7:0]         wr_addr,
    input  logic [7:0]         wr_data,
    input  logic [7:0]         rd_addr,
    output logic [7:0]         rd_data,
    output logic [3:0]         sec_u,
    output logic [2:0]         sec_d,
    output logic [3:0]         min_u,
    output logic [2:0]         min_d,
    output logic [3:0]         hrs_u,
    output logic [1:0]         hrs_d,
    output logic               pm,
    output logic [COLOR_W-1:0] color_offset,
    output logic               sec_tick,
    output logic               alarm_hit
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    function automatic logic [5:0] bcd_to_bin(input logic [1:0] tens, input logic [3:0] units);
        return ({4'b0, tens} * 6'd10) + {2'b0, units};
    endfunction

    function automatic logic [5:0] bin_to_bcd(input logic [5:0] b);
        logic [5:0] r;
        r = b;
        if (b >= 6'd20) begin
            r = b - 6'd20;
            return {2'd2, r[3:0]};
        end else if (b >= 6'd10) begin
            r = b - 6'd10;
            return {2'd1, r[3:0]};
        end
        return {2'd0, r[3:0]};
    endfunction

    function automatic logic sec_ok(input logic [7:0] d);
        return !d[7] && (d[6:4] <= 3'd5) && (d[3:0] <= 4'd9);
    endfunction

    function automatic logic hr24_ok(input logic [7:0] d);
        return (d[7:6] == 2'b00) && (d[3:0] <= 4'd9) && (bcd_to_bin(d[5:4], d[3:0]) <= 6'd23);
    endfunction

    function automatic logic hr12_ok(input logic [7:0] d);
        logic [5:0] h;
        h = bcd_to_bin(d[5:4], d[3:0]);
        return !d[6] && (d[3:0] <= 4'd9) && (h >= 6'd1) && (h <= 6'd12);
    endfunction

    logic [3:0] sec_u_q, sec_u_d, min_u_q, min_u_d, hr_u_q, hr_u_d, hrs_u_q, hrs_u_d;
    logic [2:0] sec_d_q, sec_d_d, min_d_q, min_d_d;
    logic [1:0] hr_d_q, hr_d_d, hrs_d_q, hrs_d_d;
    logic       pm_q, pm_d, mode24_q, mode24_d, run_q, run_d, alarm_en_q, alarm_en_d;
    logic [6:0] al_min_q, al_min_d;
    logic [5:0] al_hrs_q, al_hrs_d;
    logic       alarm_flag_q, alarm_flag_d, tick_pend_q, tick_pend_d;
    logic       sec_tick_q, sec_tick_d, alarm_hit_q, alarm_hit_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [7:0]         rd_data_q, rd_data_d;

    logic       wr_sec, wr_min, wr_hrs, wr_ctl, tick_wrap, pend, do_tick;
    logic       sec_max, min_max, hr_max, min_step, hr_step;
    logic [5:0] hb, disp, disp_bcd, h12, h24;

    always_comb begin
        sec_u_d = sec_u_q;  sec_d_d = sec_d_q;
        min_u_d = min_u_q;  min_d_d = min_d_q;
        hr_u_d = hr_u_q;    hr_d_d = hr_d_q;
        mode24_d = mode24_q; run_d = run_q; alarm_en_d = alarm_en_q;
        al_min_d = al_min_q; al_hrs_d = al_hrs_q;
        color_d = color_q;
        alarm_hit_d = 1'b0;
        h12 = 6'd0;
        h24 = 6'd0;

        wr_sec = wr_en && (wr_addr == 8'h00) && sec_ok(wr_data);
        wr_min = wr_en && (wr_addr == 8'h01) && sec_ok(wr_data);
        wr_hrs = wr_en && (wr_addr == 8'h02) &&
                 (mode24_q ? hr24_ok(wr_data) : hr12_ok(wr_data));
        wr_ctl = wr_en && (wr_addr == 8'h03);

        tick_wrap = run_q && (presc_q == PRESC_MAX);
        presc_d   = run_q ? (tick_wrap ? '0 : presc_q + PW'(1)) : presc_q;
        // Adjusts and time writes win; a pending tick simply waits for a free cycle.
        pend        = tick_pend_q | tick_wrap;
        do_tick     = pend && !(adj_sec || adj_min || adj_hrs || wr_sec || wr_min || wr_hrs);
        tick_pend_d = pend && !do_tick;
        sec_tick_d  = do_tick;

        sec_max  = (sec_u_q == 4'd9) && (sec_d_q == 3'd5);
        min_max  = (min_u_q == 4'd9) && (min_d_q == 3'd5);
        hr_max   = (hr_u_q == 4'd3) && (hr_d_q == 2'd2);
        min_step = (do_tick && sec_max) || adj_min;
        hr_step  = (do_tick && sec_max && min_max) || adj_hrs;

        if (do_tick || adj_sec) begin
            if (sec_u_q == 4'd9) begin
                sec_u_d = 4'd0;
                sec_d_d = sec_max ? 3'd0 : sec_d_q + 3'd1;
            end else begin
                sec_u_d = sec_u_q + 4'd1;
            end
        end
        if (min_step) begin
            color_d = color_q + COLOR_W'(1);
            if (min_u_q == 4'd9) begin
                min_u_d = 4'd0;
                min_d_d = min_max ? 3'd0 : min_d_q + 3'd1;
            end else begin
                min_u_d = min_u_q + 4'd1;
            end
        end
        if (hr_step) begin
            if (hr_max) begin
                hr_u_d = 4'd0;
                hr_d_d = 2'd0;
            end else if (hr_u_q == 4'd9) begin
                hr_u_d = 4'd0;
                hr_d_d = hr_d_q + 2'd1;
            end else begin
                hr_u_d = hr_u_q + 4'd1;
            end
        end

        if (wr_sec) begin
            sec_d_d     = wr_data[6:4];
            sec_u_d     = wr_data[3:0];
            presc_d     = '0;
            tick_pend_d = 1'b0;
        end
        if (wr_min) begin
            min_d_d = wr_data[6:4];
            min_u_d = wr_data[3:0];
        end
        if (wr_hrs) begin
            if (mode24_q) begin
                h24 = bcd_to_bin(wr_data[5:4], wr_data[3:0]);
            end else begin
                h12 = bcd_to_bin(wr_data[5:4], wr_data[3:0]);
                if (h12 == 6'd12) h24 = wr_data[7] ? 6'd12 : 6'd0;
                else              h24 = wr_data[7] ? h12 + 6'd12 : h12;
            end
            {hr_d_d, hr_u_d} = bin_to_bcd(h24);
        end
        if (wr_ctl) begin
            mode24_d   = wr_data[0];
            run_d      = wr_data[1];
            alarm_en_d = wr_data[2];
        end
        if (wr_en && (wr_addr == 8'h04) && sec_ok(wr_data)) al_min_d = wr_data[6:0];
        if (wr_en && (wr_addr == 8'h05) && hr24_ok(wr_data)) al_hrs_d = wr_data[5:0];

        if (do_tick && alarm_en_q && (sec_d_d == 3'd0) && (sec_u_d == 4'd0) &&
            ({min_d_d, min_u_d} == al_min_q) && ({hr_d_d, hr_u_d} == al_hrs_q)) begin
            alarm_hit_d = 1'b1;
        end
        alarm_flag_d = alarm_hit_d ||
                       (alarm_flag_q && !(wr_en && (wr_addr == 8'h06) && wr_data[0]));

        hb = bcd_to_bin(hr_d_d, hr_u_d);
        if (mode24_d)          disp = hb;
        else if (hb == 6'd0)   disp = 6'd12;
        else if (hb > 6'd12)   disp = hb - 6'd12;
        else                   disp = hb;
        disp_bcd = bin_to_bcd(disp);
        hrs_d_d  = disp_bcd[5:4];
        hrs_u_d  = disp_bcd[3:0];
        pm_d     = (hb >= 6'd12);

        unique case (rd_addr)
            8'h00:   rd_data_d = {1'b0, sec_d_d, sec_u_d};
            8'h01:   rd_data_d = {1'b0, min_d_d, min_u_d};
            8'h02:   rd_data_d = mode24_d ? {2'b00, hr_d_d, hr_u_d} : {pm_d, 1'b0, disp_bcd};
            8'h03:   rd_data_d = {5'b0, alarm_en_d, run_d, mode24_d};
            8'h04:   rd_data_d = {1'b0, al_min_d};
            8'h05:   rd_data_d = {2'b00, al_hrs_d};
            8'h06:   rd_data_d = {7'b0, alarm_flag_d};
            default: rd_data_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_u_q <= '0; sec_d_q <= '0; min_u_q <= '0; min_d_q <= '0;
            hr_u_q <= '0;  hr_d_q <= '0;  hrs_u_q <= '0; hrs_d_q <= '0; pm_q <= 1'b0;
            mode24_q <= (HOUR_MODE_24 != 0); run_q <= 1'b1; alarm_en_q <= 1'b0;
            al_min_q <= '0; al_hrs_q <= '0; alarm_flag_q <= 1'b0;
            presc_q <= '0; tick_pend_q <= 1'b0; color_q <= '0;
            rd_data_q <= '0; sec_tick_q <= 1'b0; alarm_hit_q <= 1'b0;
        end else begin
            sec_u_q <= sec_u_d; sec_d_q <= sec_d_d; min_u_q <= min_u_d; min_d_q <= min_d_d;
            hr_u_q <= hr_u_d;   hr_d_q <= hr_d_d;   hrs_u_q <= hrs_u_d; hrs_d_q <= hrs_d_d;
            pm_q <= pm_d;
            mode24_q <= mode24_d; run_q <= run_d; alarm_en_q <= alarm_en_d;
            al_min_q <= al_min_d; al_hrs_q <= al_hrs_d; alarm_flag_q <= alarm_flag_d;
            presc_q <= presc_d; tick_pend_q <= tick_pend_d; color_q <= color_d;
            rd_data_q <= rd_data_d; sec_tick_q <= sec_tick_d; alarm_hit_q <= alarm_hit_d;
        end
    end

    assign sec_u        = sec_u_q;
    assign sec_d        = sec_d_q;
    assign min_u        = min_u_q;
    assign min_d        = min_d_q;
    assign hrs_u        = hrs_u_q;
    assign hrs_d        = hrs_d_q;
    assign pm           = pm_q;
    assign color_offset = color_q;
    assign sec_tick     = sec_tick_q;
    assign alarm_hit    = alarm_hit_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_rtc_bcd_core.sv
// Scoreboard bench for rtc_bcd_core: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rtc_bcd_core;

    localparam int unsigned CLK_HZ = 10;
    localparam int SEL_TIME  = 0;
    localparam int SEL_RD    = 1;
    localparam int SEL_TICK  = 2;
    localparam int SEL_COLOR = 3;
    localparam int SEL_ALARM = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       adj_sec = 1'b0, adj_min = 1'b0, adj_hrs = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = 8'h00, wr_data = 8'h00, rd_addr = 8'h00;
    logic [7:0] rd_data;
    logic [3:0] sec_u, min_u, hrs_u;
    logic [2:0] sec_d, min_d;
    logic [1:0] hrs_d;
    logic       pm, sec_tick, alarm_hit;
    logic [3:0] color_offset;

    rtc_bcd_core #(
        .CLK_HZ      (CLK_HZ),
        .HOUR_MODE_24(1),
        .COLOR_W     (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .adj_sec     (adj_sec),
        .adj_min     (adj_min),
        .adj_hrs     (adj_hrs),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .sec_u       (sec_u),
        .sec_d       (sec_d),
        .min_u       (min_u),
        .min_d       (min_d),
        .hrs_u       (hrs_u),
        .hrs_d       (hrs_d),
        .pm          (pm),
        .color_offset(color_offset),
        .sec_tick    (sec_tick),
        .alarm_hit   (alarm_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Time packs as 0x0P_HH_MM_SS with P = pm.
    function automatic logic [31:0] obs(input int sel);
        case (sel)
            SEL_TIME:  return {7'b0, pm, 2'b0, hrs_d, hrs_u, 1'b0, min_d, min_u, 1'b0, sec_d, sec_u};
            SEL_RD:    return {24'h0, rd_data};
            SEL_TICK:  return {31'h0, sec_tick};
            SEL_COLOR: return {28'h0, color_offset};
            SEL_ALARM: return {31'h0, alarm_hit};
            default:   return 32'hdeadbeef;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] got;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e   = sb_q.pop_front();
            got = obs(e.sel);
            n_chk++;
            if (got === e.exp && e.cyc == cyc) n_pass++;
            else $display("FAIL %s @cyc %0d (due %0d): got %h want %h",
                          e.name, cyc, e.cyc, got, e.exp);
        end
    end

    task automatic push(input int unsigned c, input string n, input int s, input logic [31:0] e);
        exp_t x;
        x.cyc = c; x.name = n; x.sel = s; x.exp = e;
        sb_q.push_back(x);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned b;

        // Reset state.
        rd_addr = 8'h03;
        idle(3);
        push(cyc + 1, "rst_time", SEL_TIME, 32'h0);
        push(cyc + 1, "rst_rd", SEL_RD, 32'h0);
        push(cyc + 1, "rst_tick", SEL_TICK, 32'h0);
        push(cyc + 1, "rst_color", SEL_COLOR, 32'h0);
        idle(1);
        reset_n = 1'b1;
        b = cyc;

        // First tick at cycle CLK_HZ, then every CLK_HZ cycles.
        push(b + 1, "ctl_reset_rd", SEL_RD, 32'h03);
        for (int k = 1; k <= 30; k++) begin
            push(b + k, "tick_period", SEL_TICK, {31'h0, (k % 10) == 0});
            if ((k % 10) == 0) push(b + k, "tick_time", SEL_TIME, k / 10);
        end
        idle(30);

        // 23:59:59 rolls to 00:00:00 with a colour step.
        wr(8'h02, 8'h23); wr(8'h01, 8'h59); wr(8'h00, 8'h59);
        b = cyc;
        push(b + 1, "set_time", SEL_TIME, 32'h01235959);
        push(b + 1, "set_color", SEL_COLOR, 32'h0);
        push(b + 10, "roll_time", SEL_TIME, 32'h00000000);
        push(b + 10, "roll_tick", SEL_TICK, 32'h1);
        push(b + 10, "roll_color", SEL_COLOR, 32'h1);
        idle(10);

        // 12 h display and readback.
        rd_addr = 8'h02;
        wr(8'h02, 8'h23); wr(8'h01, 8'h59); wr(8'h00, 8'h59);
        b = cyc;
        push(b + 1, "h12_time", SEL_TIME, 32'h01115959);
        push(b + 1, "h12_rd", SEL_RD, 32'h91);
        wr(8'h03, 8'h02);
        push(b + 10, "h12_roll_time", SEL_TIME, 32'h00120000);
        push(b + 10, "h12_roll_rd", SEL_RD, 32'h12);
        push(b + 10, "h12_roll_tick", SEL_TICK, 32'h1);
        push(b + 10, "h12_roll_color", SEL_COLOR, 32'h2);
        idle(9);
        wr(8'h03, 8'h03);

        // adj_sec in the tick cycle defers the tick by one cycle.
        wr(8'h02, 8'h00); wr(8'h01, 8'h00); wr(8'h00, 8'h58);
        b = cyc;
        idle(9);
        push(b + 10, "adj_time", SEL_TIME, 32'h00000059);
        push(b + 10, "adj_notick", SEL_TICK, 32'h0);
        push(b + 11, "defer_time", SEL_TIME, 32'h00000100);
        push(b + 11, "defer_tick", SEL_TICK, 32'h1);
        push(b + 11, "defer_color", SEL_COLOR, 32'h3);
        adj_sec = 1'b1;
        idle(1);
        adj_sec = 1'b0;
        idle(1);

        // Alarm at 06:30.
        rd_addr = 8'h06;
        wr(8'h05, 8'h06); wr(8'h04, 8'h30); wr(8'h03, 8'h07);
        wr(8'h02, 8'h06); wr(8'h01, 8'h29); wr(8'h00, 8'h59);
        b = cyc;
        push(b + 9, "alarm_pre", SEL_ALARM, 32'h0);
        push(b + 10, "alarm_time", SEL_TIME, 32'h00063000);
        push(b + 10, "alarm_hit", SEL_ALARM, 32'h1);
        push(b + 10, "alarm_flag", SEL_RD, 32'h01);
        push(b + 10, "alarm_color", SEL_COLOR, 32'h4);
        push(b + 11, "alarm_once", SEL_ALARM, 32'h0);
        push(b + 11, "alarm_flag_hold", SEL_RD, 32'h01);
        idle(11);
        push(cyc + 1, "alarm_w1c", SEL_RD, 32'h00);
        wr(8'h06, 8'h01);

        // Stopped clock; illegal writes are dropped.
        rd_addr = 8'h02;
        wr(8'h03, 8'h05);
        wr(8'h02, 8'h07); wr(8'h01, 8'h08); wr(8'h00, 8'h09);
        wr(8'h00, 8'h5A); wr(8'h02, 8'h24); wr(8'h01, 8'h60);
        b = cyc;
        push(b + 1, "illegal_time", SEL_TIME, 32'h00070809);
        push(b + 1, "illegal_rd", SEL_RD, 32'h07);
        push(b + 12, "stopped_time", SEL_TIME, 32'h00070809);
        idle(12);

        // Asynchronous reset mid-second.
        wr(8'h03, 8'h07);
        idle(4);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        push(cyc, "arst_time", SEL_TIME, 32'h0);
        push(cyc, "arst_rd", SEL_RD, 32'h0);
        push(cyc, "arst_color", SEL_COLOR, 32'h0);
        push(cyc, "arst_tick", SEL_TICK, 32'h0);
        push(cyc, "arst_alarm", SEL_ALARM, 32'h0);
        idle(2);
        rd_addr = 8'h03;
        reset_n = 1'b1;
        push(cyc + 1, "arst_ctl_rd", SEL_RD, 32'h03);
        idle(3);

        n_chk++;
        if ({pm, hrs_d, hrs_u, min_d, min_u, sec_d, sec_u} === 23'h0) n_pass++;
        else $display("FAIL post_rst_time: got %b", {pm, hrs_d, hrs_u, min_d, min_u, sec_d, sec_u});
        n_chk++;
        if (rd_data === 8'h03) n_pass++;
        else $display("FAIL post_rst_rd: got %h want 03", rd_data);
        n_chk++;
        if (sec_tick === 1'b0) n_pass++;
        else $display("FAIL post_rst_tick: got %b want 0", sec_tick);
        n_chk++;
        if (alarm_hit === 1'b0) n_pass++;
        else $display("FAIL post_rst_alarm: got %b want 0", alarm_hit);
        n_chk++;
        if (color_offset === 4'h0) n_pass++;
        else $display("FAIL post_rst_color: got %h want 0", color_offset);

        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_chk++;
            $display("FAIL %s: never compared, got none want %h", e.name, e.exp);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
